// File: rtl/screen_fade_sequencer.sv
// Purpose : sequences title/game/highscore screen changes: fade out to black, swap the mux select, fade back in.
// Latency : ack one cycle after the request; full change takes 30*FADE_FRAMES_PER_STEP frame ticks plus 3 cycles.
// Backpres: requests arriving while busy are dropped (no ack, no queue); the master retries after switch_done.
//
// Ports:
//   pclk, rst        pixel clock, asynchronous active-low reset
//   vsync_in         timing-bus vsync; its rising edge is the frame tick
//   req, req_screen  request strobe and target screen (0 title, 1 game, 2 highscore, 3 invalid)
//   ack              one-cycle pulse when a request is accepted
//   sel              one-hot screen-mux select (bit0 title, bit1 game, bit2 highscore)
//   fade_level       brightness to the RGB scaler, 15 = full, 0 = black
//   blank_force      forces RGB to zero
//   busy             high while a transition is in progress
//   switch_done      one-cycle pulse when a request has been fully serviced
module screen_fade_sequencer #(
  parameter int unsigned FADE_FRAMES_PER_STEP = 2,
  parameter logic [2:0]  SEL_RESET            = 3'b001
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       req,
  input  logic [1:0] req_screen,
  output logic       ack,
  output logic [2:0] sel,
  output logic [3:0] fade_level,
  output logic       blank_force,
  output logic       busy,
  output logic       switch_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_OUT,
    S_SWAP,
    S_FADE_IN,
    S_DONE
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(FADE_FRAMES_PER_STEP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] fade_q, fade_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] tgt_q, tgt_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       blank_q, blank_d;
  logic       vsync_prev_q;

  logic       tick;
  logic [2:0] req_onehot;

  assign tick       = vsync_in & ~vsync_prev_q;
  assign req_onehot = 3'b001 << req_screen;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fade_d  = fade_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A tick in the acceptance cycle is deliberately not counted.
        if (req && (req_screen != 2'd3)) begin
          ack_d = 1'b1;
          if (req_onehot == sel_q) begin
            // Already showing that screen: acknowledge and complete at once.
            done_d = 1'b1;
          end else begin
            tgt_d   = req_onehot;
            cnt_d   = '0;
            state_d = S_FADE_OUT;
          end
        end
      end

      S_FADE_OUT: begin
        if (fade_q == 4'd0) begin
          // Output has been black for a full cycle, so the select may move now;
          // loading it on entry makes the new select visible during SWAP.
          state_d = S_SWAP;
          sel_d   = tgt_q;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d  = '0;
            fade_d = fade_q - 4'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_SWAP: begin
        cnt_d   = '0;
        state_d = S_FADE_IN;
      end

      S_FADE_IN: begin
        if (fade_q == 4'd15) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d  = '0;
            fade_d = fade_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered alongside the state so they line up with it.
    busy_d  = (state_d != S_IDLE);
    done_d  = done_d | (state_d == S_DONE);
    blank_d = (state_d == S_SWAP) | (fade_d == 4'd0);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fade_q       <= 4'd15;
      sel_q        <= SEL_RESET;
      tgt_q        <= SEL_RESET;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      blank_q      <= 1'b0;
      // Starts high so a vsync already high at reset release is not a tick.
      vsync_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fade_q       <= fade_d;
      sel_q        <= sel_d;
      tgt_q        <= tgt_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      blank_q      <= blank_d;
      vsync_prev_q <= vsync_in;
    end
  end

  assign ack         = ack_q;
  assign sel         = sel_q;
  assign fade_level  = fade_q;
  assign blank_force = blank_q;
  assign busy        = busy_q;
  assign switch_done = done_q;

endmodule
